// File: rtl/reg_bus_sequencer.sv
// Register_File bus master: runs one MOVE/LOAD/READ(/INC) transfer per command. Optional INC op: define REG_BUS_SEQ_INC_EN.
// Latency from accept to rsp_valid: MOVE/INC 3 cycles, LOAD/READ 2, illegal command 1.
// cmd_ready is high only in IDLE; cmd_valid while busy is ignored. The response cannot be stalled.
module reg_bus_sequencer #(
    parameter int REG_COUNT = 11,
    parameter int REG_WIDTH = 12,
    parameter int IDX_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [IDX_W-1:0]     cmd_src,
    input  logic [IDX_W-1:0]     cmd_dst,
    input  logic [REG_WIDTH-1:0] cmd_imm,
    output logic [REG_COUNT-1:0] rf_read_en,
    output logic [REG_COUNT-1:0] rf_write_en,
    output logic [REG_WIDTH-1:0] rf_datain,
    input  logic [REG_WIDTH-1:0] rf_dataout,
    output logic                 rsp_valid,
    output logic [REG_WIDTH-1:0] rsp_data,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_MOVE = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;
    localparam logic [1:0] OP_INC  = 2'b11;

    // One extra bit so REG_COUNT == 2**IDX_W is still representable.
    localparam logic [IDX_W:0] RC_L = (IDX_W+1)'(REG_COUNT);

    logic [1:0]           r_state;
    logic [1:0]           r_op;
    logic [IDX_W-1:0]     r_dst;
    logic [REG_WIDTH-1:0] r_bus_q;
    logic [REG_COUNT-1:0] r_read_en;
    logic [REG_COUNT-1:0] r_write_en;
    logic [REG_WIDTH-1:0] r_datain;
    logic                 r_rsp_valid;
    logic [REG_WIDTH-1:0] r_rsp_data;
    logic                 r_rsp_err;

    logic                 w_accept;
    logic                 w_src_bad;
    logic                 w_dst_bad;
    logic                 w_op_bad;
    logic                 w_err;
    logic [REG_WIDTH-1:0] w_rd_val;

    assign w_accept  = cmd_valid && (r_state == S_IDLE);
    // LOAD has no source, READ has no destination; only the indices actually used are checked.
    assign w_src_bad = (cmd_op != OP_LOAD) && ({1'b0, cmd_src} >= RC_L);
    assign w_dst_bad = (cmd_op != OP_READ) && ({1'b0, cmd_dst} >= RC_L);

`ifdef REG_BUS_SEQ_INC_EN
    assign w_op_bad  = 1'b0;
    // INC rides the MOVE datapath with a +1 on the sampled value (wraps modulo 2**REG_WIDTH).
    assign w_rd_val  = (r_op == OP_INC) ? rf_dataout + REG_WIDTH'(1) : rf_dataout;
`else
    assign w_op_bad  = (cmd_op == OP_INC);
    assign w_rd_val  = rf_dataout;
`endif

    assign w_err = w_src_bad || w_dst_bad || w_op_bad;

    // Sequencer state and all bus/response registers advance together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= OP_MOVE;
            r_dst       <= '0;
            r_bus_q     <= '0;
            r_read_en   <= '0;
            r_write_en  <= '0;
            r_datain    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= cmd_op;
                        r_dst <= cmd_dst;
                        if (w_err) begin
                            r_state     <= S_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= '0;
                        end else if (cmd_op == OP_LOAD) begin
                            r_state    <= S_WR;
                            r_bus_q    <= cmd_imm;
                            r_write_en <= REG_COUNT'(1) << cmd_dst;
                            r_datain   <= cmd_imm;
                        end else begin
                            r_state   <= S_RD;
                            r_read_en <= REG_COUNT'(1) << cmd_src;
                        end
                    end
                end
                S_RD: begin
                    // Read data is valid only while read_en is one-hot, i.e. in this state.
                    r_read_en <= '0;
                    r_bus_q   <= w_rd_val;
                    if (r_op == OP_READ) begin
                        r_state     <= S_DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_rd_val;
                    end else begin
                        r_state    <= S_WR;
                        r_write_en <= REG_COUNT'(1) << r_dst;
                        r_datain   <= w_rd_val;
                    end
                end
                S_WR: begin
                    r_write_en  <= '0;
                    r_state     <= S_DONE;
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= r_bus_q;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_data  <= '0;
                end
            endcase
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign rf_read_en  = r_read_en;
    assign rf_write_en = r_write_en;
    assign rf_datain   = r_datain;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;

endmodule
